// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory controller.
package dmem_pkg;

    // Access sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_DEPTH       = 64;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    // Wide enough for a wait-state count of 0..15
    localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Data word storage: one synchronous write port, one combinational read port,
// every word cleared asynchronously while rst_n is low.
module dmem_array #(
    parameter int DataWidth = 32,
    parameter int Depth     = 64,
    parameter int AddrW     = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [AddrW-1:0]     waddr,
    input  logic [DataWidth-1:0] wdata,
    input  logic [AddrW-1:0]     raddr,
    output logic [DataWidth-1:0] rdata
);

    logic [DataWidth-1:0] mem [Depth];

    // Word storage with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory controller: latches a load/store request, holds the
// pipeline with Stall for the configured wait states, commits the access on
// the edge entering DONE and pulses Ready for one cycle.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses
// (store suppressed, load ignored, MisalignErr pulsed with Ready).
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DataWidth  = 32,
    parameter int Depth      = DEFAULT_DEPTH,
    parameter int WaitCycles = DEFAULT_WAIT_CYCLES
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic                 MemtoReg,
    input  logic [DataWidth-1:0] ALUOut,
    input  logic [DataWidth-1:0] WriteData,
    output logic [DataWidth-1:0] ReadData,
    output logic [DataWidth-1:0] Result,
    output logic                 Stall,
    output logic                 Ready
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic                 MisalignErr
`endif
);

    localparam int AddrW = $clog2(Depth);
    localparam logic [CNT_W-1:0] CntInit =
        (WaitCycles > 0) ? CNT_W'(WaitCycles - 1) : '0;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [AddrW-1:0]     idx_q;
    logic [DataWidth-1:0] wdata_q;
    logic                 wr_q, rd_q;
    logic                 req, enter_done;

    logic [AddrW-1:0]     acc_idx;
    logic [DataWidth-1:0] acc_wdata;
    logic                 acc_wr, acc_rd, acc_mis;
    logic                 arr_we, rd_load;
    logic [DataWidth-1:0] arr_rdata;

    assign req = MemRead | MemWrite;

    // Next-state, stall and ready decode
    always_comb begin
        state_nxt  = state;
        Stall      = 1'b0;
        Ready      = 1'b0;
        enter_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    Stall = 1'b1;
                    if (WaitCycles == 0) begin
                        state_nxt  = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                Stall = 1'b1;
                if (cnt == '0) begin
                    state_nxt  = DONE;
                    enter_done = 1'b1;
                end
            end
            DONE: begin
                Ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Stall must drop the moment reset is asserted, even with a request pending
        if (!RST) begin
            Stall = 1'b0;
        end
    end

    // In IDLE the access is taken straight from the inputs (zero-wait case);
    // afterwards only the latched copy is used so input changes are ignored.
    assign acc_idx   = (state == IDLE) ? ALUOut[AddrW+1:2] : idx_q;
    assign acc_wdata = (state == IDLE) ? WriteData : wdata_q;
    assign acc_wr    = (state == IDLE) ? MemWrite : wr_q;
    assign acc_rd    = (state == IDLE) ? (MemRead & ~MemWrite) : rd_q;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic mis_q;
    assign acc_mis     = (state == IDLE) ? (ALUOut[1:0] != 2'b00) : mis_q;
    assign MisalignErr = (state == DONE) & mis_q;
`else
    assign acc_mis = 1'b0;
`endif

    assign arr_we  = enter_done & acc_wr & ~acc_mis;
    assign rd_load = enter_done & acc_rd & ~acc_mis;

    // State register
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request latch and wait-state countdown
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            cnt     <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else if (state == IDLE && req) begin
            cnt     <= CntInit;
            idx_q   <= ALUOut[AddrW+1:2];
            wdata_q <= WriteData;
            wr_q    <= MemWrite;
            rd_q    <= MemRead & ~MemWrite;
`ifdef DMEM_MISALIGN_TRAP_EN
            mis_q   <= (ALUOut[1:0] != 2'b00);
`endif
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Load data register, updated only when a load completes
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            ReadData <= '0;
        end else if (rd_load) begin
            ReadData <= arr_rdata;
        end
    end

    assign Result = MemtoReg ? ReadData : ALUOut;

    dmem_array #(
        .DataWidth (DataWidth),
        .Depth     (Depth),
        .AddrW     (AddrW)
    ) u_array (
        .clk   (clk),
        .rst_n (RST),
        .we    (arr_we),
        .waddr (acc_idx),
        .wdata (acc_wdata),
        .raddr (acc_idx),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a scoreboard of expected completions.
module tb_data_mem_ctrl;

    localparam int WC = 2;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [31:0] rd;
        logic        mis;
    } exp_t;

    logic        clk, RST;
    logic        MemRead, MemWrite, MemtoReg;
    logic [31:0] ALUOut, WriteData, ReadData, Result;
    logic        Stall, Ready;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        MisalignErr;
`endif

    int          tests  = 0;
    int          failed = 0;
    exp_t        sb[$];
    logic [31:0] mem_m [64];
    logic [31:0] rd_m;

    data_mem_ctrl #(
        .DataWidth  (32),
        .Depth      (64),
        .WaitCycles (WC)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemtoReg  (MemtoReg),
        .ALUOut    (ALUOut),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Result    (Result),
        .Stall     (Stall),
        .Ready     (Ready)
`ifdef DMEM_MISALIGN_TRAP_EN
        ,
        .MisalignErr (MisalignErr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One memory instruction: update the model, push the expectation, drive the
    // request, scramble the inputs during WAIT and check the completion cycle.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic mtr, input logic [31:0] addr,
                          input logic [31:0] wdata);
        exp_t e;
        int   idx;
        logic trap;
        int   stalls;
        bit   got;
        idx  = int'(addr[7:2]);
        trap = TRAP && (addr[1:0] != 2'b00);
        if (wr) begin
            if (!trap) mem_m[idx] = wdata;
        end else if (rd && !trap) begin
            rd_m = mem_m[idx];
        end
        e.rd  = rd_m;
        e.mis = trap;
        sb.push_back(e);

        @(negedge clk);
        MemRead = rd; MemWrite = wr; MemtoReg = mtr; ALUOut = addr; WriteData = wdata;
        stalls = 0;
        got    = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (Ready) begin
                got = 1'b1;
                chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
                if (sb.size() > 0) e = sb.pop_front();
                chk({tag, "_latency"}, c, WC + 2);
                chk({tag, "_stall_cycles"}, stalls, WC + 1);
                chk({tag, "_stall_in_done"}, {31'b0, Stall}, 0);
                chk({tag, "_readdata"}, ReadData, e.rd);
                chk({tag, "_result"}, Result, mtr ? e.rd : ALUOut);
`ifdef DMEM_MISALIGN_TRAP_EN
                chk({tag, "_misalign"}, {31'b0, MisalignErr}, {31'b0, e.mis});
`endif
                break;
            end
            if (Stall) stalls++;
            if (c == 2) begin
                ALUOut    = addr ^ 32'h0000_0F5D;
                WriteData = ~wdata;
            end
            @(negedge clk);
        end
        chk({tag, "_ready_seen"}, {31'b0, got}, 1);
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0;
        #1;
        chk({tag, "_ready_after"}, {31'b0, Ready}, 0);
        chk({tag, "_stall_after"}, {31'b0, Stall}, 0);
    endtask

    initial begin
        int pulses;
        RST = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0;
        ALUOut = 32'h0; WriteData = 32'h0;
        for (int i = 0; i < 64; i++) mem_m[i] = 32'h0;
        rd_m = 32'h0;

        // Reset state
        #12;
        chk("rst_readdata", ReadData, 0);
        chk("rst_stall", {31'b0, Stall}, 0);
        chk("rst_ready", {31'b0, Ready}, 0);
        @(negedge clk);
        RST = 1'b1;

        // Non-memory instruction: no stall, Result passes ALUOut
        @(negedge clk);
        ALUOut = 32'hCAFE_0001; MemtoReg = 1'b0;
        #1;
        chk("nomem_stall", {31'b0, Stall}, 0);
        chk("nomem_result", Result, 32'hCAFE_0001);
        @(negedge clk);
        #1;
        chk("nomem_ready", {31'b0, Ready}, 0);

        access("st_beef", 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
        access("ld_beef_m1", 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
        access("ld_beef_m0", 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        access("st_wrap", 1'b0, 1'b1, 1'b0, 32'h100, 32'h1234);
        access("ld_word0", 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
        access("rw_both", 1'b1, 1'b1, 1'b1, 32'h8, 32'hA5A5_A5A5);
        access("ld_word2", 1'b1, 1'b0, 1'b1, 32'h8, 32'h0);

        // ReadData holds between loads
        @(negedge clk);
        MemtoReg = 1'b1; ALUOut = 32'h3C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("hold_result", Result, 32'hA5A5_A5A5);
            chk("hold_stall", {31'b0, Stall}, 0);
        end

        // Reset during the second WAIT cycle aborts the store
        @(negedge clk);
        MemWrite = 1'b1; ALUOut = 32'h20; WriteData = 32'h55; MemtoReg = 1'b0;
        #1;
        chk("abort_stall_idle", {31'b0, Stall}, 1);
        @(negedge clk);
        #1;
        chk("abort_stall_w1", {31'b0, Stall}, 1);
        @(negedge clk);
        RST = 1'b0;
        #1;
        chk("abort_stall", {31'b0, Stall}, 0);
        chk("abort_ready", {31'b0, Ready}, 0);
        chk("abort_readdata", ReadData, 0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (Ready) pulses++;
        end
        MemWrite = 1'b0;
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (Ready) pulses++;
        end
        chk("abort_no_ready", pulses, 0);
        for (int i = 0; i < 64; i++) mem_m[i] = 32'h0;
        rd_m = 32'h0;
        access("ld_after_abort", 1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
        access("ld_cleared", 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);

        // Misaligned accesses (trapped or ignored depending on build)
        access("st_aligned", 1'b0, 1'b1, 1'b0, 32'h10, 32'h99);
        access("st_misal", 1'b0, 1'b1, 1'b0, 32'h12, 32'h77);
        access("ld_misal", 1'b1, 1'b0, 1'b1, 32'h13, 32'h0);
        access("ld_word4", 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Absolute time limit so the bench always ends on its own
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
